// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit-port arbiter.
package uart_arb_pkg;

    localparam int BYTE_W   = 8;
    localparam int MAX_NREQ = 8;

    typedef enum logic [1:0] {IDLE, SEND, ACK, HOLD} arb_state_t;

    function automatic logic [MAX_NREQ-1:0] onehot(input int unsigned idx);
        return MAX_NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side handshake bundle: one valid/data/last lane per requester plus ready and grant back.
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int NREQ = 4
);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*BYTE_W-1:0] req_data;
    logic [NREQ-1:0]        req_last;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        grant;

    modport master (
        output req_valid, req_data, req_last,
        input  req_ready, grant
    );

    modport slave (
        input  req_valid, req_data, req_last,
        output req_ready, grant
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin finder: first set request scanning upward from last_idx+1 with wrap.
module rr_pick #(
    parameter  int NREQ  = 4,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_idx,
    output logic             found,
    output logic [IDX_W-1:0] winner
);

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int step);
        return IDX_W'((int'(base) + step) % NREQ);
    endfunction

    // Scan from the farthest offset down so the nearest requester after last_idx is the final write.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[wrap_idx(last_idx, k)]) begin
                found  = 1'b1;
                winner = wrap_idx(last_idx, k);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART byte port among NREQ requesters.
// Define UART_ARB_TMO_EN to add the ACK timeout counter and sticky tmo_err flag.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TMO_CYC = 1024
) (
    input  logic              hwclk,
    input  logic              reset,
    uart_tx_arbiter_if.slave  req,
    output logic [BYTE_W-1:0] txdata,
    output logic              txclk,
    input  logic              txready,
    output logic              busy,
    output logic              tmo_err
);

    localparam int IDX_W = $clog2(NREQ);

    if (NREQ < 2 || NREQ > MAX_NREQ || TMO_CYC < 1) begin : g_param_check
        $error("uart_tx_arbiter: NREQ must be 2..8 and TMO_CYC at least 1");
    end

    arb_state_t        state_q, state_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   ready_q, ready_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic              locked_q, locked_d;
    logic              strobe;
    logic              tmo_hit;

    logic              found;
    logic [IDX_W-1:0]  win_idx;
    logic [NREQ-1:0]   win_oh;
    logic [BYTE_W-1:0] req_byte [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_byte[i] = req.req_data[i*BYTE_W +: BYTE_W];
        end
    end

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req      (req.req_valid),
        .last_idx (last_q),
        .found    (found),
        .winner   (win_idx)
    );

    assign win_oh = NREQ'(onehot(32'(win_idx)));

`ifdef UART_ARB_TMO_EN
    localparam int CNT_W = $clog2(TMO_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             tmo_q;

    // The counter restarts every time ACK is entered, so it measures only the current wait.
    assign tmo_hit = (state_q == ACK) && txready && (cnt_q == CNT_W'(TMO_CYC - 1));

    always_ff @(posedge hwclk) begin
        if (reset) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            if (state_q != ACK) begin
                cnt_q <= '0;
            end else if (!tmo_hit) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (tmo_hit) begin
                tmo_q <= 1'b1;
            end
        end
    end

    assign tmo_err = tmo_q;
`else
    assign tmo_hit = 1'b0;
    assign tmo_err = 1'b0;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_d  = state_q;
        data_d   = data_q;
        grant_d  = grant_q;
        ready_d  = '0;
        last_d   = last_q;
        locked_d = locked_q;
        strobe   = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    data_d   = req_byte[win_idx];
                    ready_d  = win_oh;
                    grant_d  = win_oh;
                    last_d   = win_idx;
                    locked_d = ~req.req_last[win_idx];
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (txready) begin
                    strobe  = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!txready || tmo_hit) begin
                    if (locked_q) begin
                        state_d = HOLD;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            HOLD: begin
                // Only the owner is looked at; the grant register already holds its one-hot.
                if (req.req_valid[last_q]) begin
                    data_d   = req_byte[last_q];
                    ready_d  = grant_q;
                    locked_d = ~req.req_last[last_q];
                    state_d  = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge hwclk) begin
        // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            state_q  <= IDLE;
            data_q   <= '0;
            grant_q  <= '0;
            ready_q  <= '0;
            last_q   <= IDX_W'(NREQ - 1);
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            grant_q  <= grant_d;
            ready_q  <= ready_d;
            last_q   <= last_d;
            locked_q <= locked_d;
        end
    end

    // The strobe fires in the first SEND cycle that sees txready; a pending reset suppresses it.
    assign txclk         = strobe & ~reset;
    assign txdata        = data_q;
    assign busy          = (state_q != IDLE);
    assign req.req_ready = ready_q;
    assign req.grant     = grant_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single board UART transmit byte port (txdata/txclk/txready) between NREQ on-chip requesters, e.g. debug dump, seven-segment mirror and status reporter.
- Round-robin arbitration per packet: a winner holds the port until it sends a byte flagged last.
- Sits between team logic and the FPGA top UART pins; drives txclk as a one-cycle load strobe.

Parameters:
NREQ, 4, number of requesters (2..8)
TMO_CYC, 1024, cycles allowed for txready to drop after a strobe (only with UART_ARB_TMO_EN)

Ports:
hwclk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  NREQ  requester i has a byte on req_data[i]
req_data  input  NREQ*8  byte per requester, requester i at bits [8i+7:8i]
req_last  input  NREQ  byte on req_data[i] ends its packet
req_ready  output  NREQ  one-cycle pulse: byte from requester i captured this cycle
grant  output  NREQ  one-hot owner of the port; zero when idle
txdata  output  8  registered byte to UART
txclk  output  1  one-cycle load strobe to UART
txready  input  1  UART can accept a byte; drops while shifting
busy  output  1  high in any state except IDLE
tmo_err  output  1  sticky timeout flag (feature only; tied 0 otherwise)

Behaviour:
- Reset: state IDLE, grant=0, req_ready=0, txdata=8'h00, txclk=0, busy=0, tmo_err=0, locked=0, last_idx=NREQ-1 (so requester 0 has top priority). Reset mid-packet discards the packet silently, with no txclk.
- IDLE:
  - If any req_valid, pick the first set bit scanning from last_idx+1 upward with wrap.
  - Same cycle: register txdata <= req_data[w], pulse req_ready[w], grant <= onehot(w), last_idx <= w, locked <= ~req_last[w]. Go SEND.
- SEND:
  - Wait for txready=1. Then assert txclk for exactly one cycle and go ACK.
  - txdata is held stable from capture until leaving ACK.
- ACK:
  - Wait for txready=0 (UART has taken the byte).
  - Then go HOLD if locked, else go IDLE with grant <= 0.
  - With no timeout, ACK waits forever.
- HOLD:
  - grant stays on w; other requesters are ignored.
  - When req_valid[w]=1: capture byte, pulse req_ready[w], locked <= ~req_last[w], go SEND.
- Latency: req_valid to req_ready is 1 cycle from IDLE. Capture to txclk is at least 1 cycle, gated by txready.
- req_ready never pulses in SEND or ACK. A requester must hold req_valid and req_data until req_ready.
- Simultaneous requests: round-robin only. A requester that just finished a packet is lowest priority next.
- Single-requester case: back-to-back single-byte packets from the same requester are allowed.
- Valid dropped in HOLD: port stays locked indefinitely (documented; no starvation guard in base build).
- req_valid with req_last on a non-owner during HOLD is ignored until that requester wins arbitration.

Optional Feature:
UART_ARB_TMO_EN:
- When defined: a counter runs in ACK. If txready is still 1 after TMO_CYC cycles, set tmo_err (sticky until reset) and leave ACK as if txready had dropped.
- When undefined: no counter; tmo_err tied to 0; ACK waits indefinitely.

Decomposition:
- Package uart_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, SEND, ACK, HOLD} arb_state_t
  - localparam BYTE_W=8
  - function onehot(idx)
- Sub-module rr_pick: combinational round-robin finder. Inputs: req vector and last_idx. Outputs: found and winner index. Parameterised by NREQ.
- The FSM, data register and counter stay in uart_tx_arbiter.

Test Plan:
- Single byte: req_valid=4'b0010, req_data[1]=8'h41, req_last[1]=1, txready=1.
  - req_ready[1] pulses the next cycle, txdata=8'h41, one txclk, grant=4'b0010.
  - Return to IDLE with grant=0 after txready drops.
- Round-robin: requesters 0, 2 and 3 valid with single-byte packets, held continuously → grant order 0, 2, 3, 0. Each txclk carries 8'h30+i.
- Packet lock: requester 1 sends 8'hA0, 8'hA1, 8'hA2 (last on A2) while requester 0 is valid.
  - Three txclk pulses carry A0, A1, A2 in order before any grant to 0.
- Backpressure: hold txready=0 for 50 cycles after capture → no txclk and txdata stable during that time; txclk fires on the first cycle txready=1.
- Reset mid-packet: assert reset in HOLD → next cycle all outputs at reset values. The remaining bytes are not sent, and requester 0 wins the next contention.
- UART_ARB_TMO_EN with TMO_CYC=16: keep txready=1 after the strobe → tmo_err=1 after 16 cycles, FSM returns to IDLE, and the next packet is still arbitrated.
